axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master. Converts one-cycle read/write command pulses from local logic into AXI4-Lite transactions.
- Returns the response code, and read data for reads, to the local logic.
- Drives the S_AXI_* port of our register-file slaves, e.g. the fill/read control block. Used by on-chip sequencers and by the bench as a bus driver.
- Includes a per-transaction watchdog so a non-responding slave is reported rather than silently hanging the sequencer.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles from command acceptance to final handshake before the watchdog fires; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_write  in  1  one-cycle pulse: start write of cmd_wdata to cmd_addr
- cmd_read  in  1  one-cycle pulse: start read of cmd_addr
- cmd_addr  in  32  byte address; sampled when a command is accepted
- cmd_wdata  in  32  write data; sampled when a command is accepted
- idle  out  1  1 = ready to accept a command
- done  out  1  one-cycle pulse: transaction finished
- resp  out  2  BRESP/RRESP of the last transaction (0 OKAY, 2 SLVERR, 3 DECERR)
- rdata  out  32  RDATA of the last completed read
- timed_out  out  1  sticky: watchdog fired
- M_AXI_AWADDR/AWVALID/AWPROT  out  32/1/3 ; M_AXI_AWREADY  in  1
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1 ; M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2 ; M_AXI_BVALID  in  1 ; M_AXI_BREADY  out  1
- M_AXI_ARADDR/ARVALID/ARPROT  out  32/1/3 ; M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32 ; M_AXI_RRESP  in  2 ; M_AXI_RVALID  in  1 ; M_AXI_RREADY  out  1

Behaviour:
- Reset values: all VALID/READY outputs 0; done 0; resp 0; rdata 0; timed_out 0; address/data outputs 0; state IDLE.
- Reset is asynchronous and may occur mid-transaction. The master abandons the transaction and returns to IDLE. No done pulse is issued.
- Constant outputs: AWPROT = ARPROT = 3'b000; WSTRB = 4'hF.
- All outputs are registered. idle = 1 exactly when the state is IDLE.

State machine:
- IDLE:
  - cmd_write=1 → latch addr/data; next cycle AWVALID=1 and WVALID=1; go to WR_AW_W.
  - cmd_read=1 (and cmd_write=0) → latch addr; next cycle ARVALID=1; go to RD_AR.
  - Both commands set in the same cycle → the write is taken and the read is dropped.
  - Commands outside IDLE are ignored.
- WR_AW_W:
  - AWVALID drops the cycle after AWREADY&AWVALID. WVALID drops the cycle after WREADY&WVALID. The two are tracked independently; either may complete first or both may complete in the same cycle.
  - Once both have handshaken, go to WR_B with BREADY=1.
- WR_B: on BVALID&BREADY → BREADY=0, resp=BRESP, done=1 for one cycle, return to IDLE.
- RD_AR: on ARREADY&ARVALID → ARVALID=0, RREADY=1, go to RD_R.
- RD_R: on RVALID&RREADY → RREADY=0, rdata=RDATA, resp=RRESP, done=1, return to IDLE.
- rdata is unchanged by writes.
- VALID is never withdrawn before its handshake, per AXI.

Latency:
- Command-to-VALID is 1 cycle.
- With a zero-wait slave, done for a write asserts 3 cycles after cmd_write: AW/W handshake at +1, B at +2, done at +3. A read has the same latency.

Watchdog:
- A 32-bit counter clears on command acceptance and increments every cycle outside IDLE.
- When the count reaches TIMEOUT_CYCLES (≠0), the FSM enters HUNG: timed_out=1, done=1 for one cycle, resp=2 (SLVERR).
- In HUNG, the outstanding VALIDs stay asserted (legal AXI) and idle stays 0. Only reset exits HUNG.
- A handshake that completes in the same cycle the count reaches the limit wins: normal completion, no timeout.

Test Plan:
- Write with a zero-wait slave: cmd_write, addr 0x4, data 0x12345678 → AWADDR=0x4, WDATA=0x12345678, WSTRB=F, done at cycle +3, resp=0.
- Skewed write: AWREADY at +1, WREADY at +5 → AWVALID low from +2, WVALID held until +5, BREADY only after +5, then done.
- Read: addr 0x0, slave returns RDATA=314159 with 4 RVALID wait cycles → rdata=314159, resp=0, single done pulse, idle=1 next cycle.
- Error passthrough: write to addr 0x40 with slave returning DECERR → resp=3. Then a read returning 0xAA → rdata=0xAA, resp=0.
- Timeout with TIMEOUT_CYCLES=16: the slave never asserts ARREADY → done and timed_out=1 at cycle 16 after acceptance, resp=2, ARVALID held, idle=0. Asserting reset → all outputs return to reset values.
- Simultaneous cmd_write and cmd_read, then cmd_read while busy → exactly one write performed, no AR issued, exactly one done pulse.

Source files
------------

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between a single-outstanding command master and a register-file slave.
interface axil_cmd_master_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [2:0]  awprot;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic [2:0]  arprot;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
           araddr, arvalid, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
           araddr, arvalid, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one-cycle read/write pulses into bus
// transactions and reports response, read data and a watchdog timeout.
module axil_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_write,
  input  logic                cmd_read,
  input  logic [31:0]         cmd_addr,
  input  logic [31:0]         cmd_wdata,
  output logic                idle,
  output logic                done,
  output logic [1:0]          resp,
  output logic [31:0]         rdata,
  output logic                timed_out,
  axil_cmd_master_if.master   m_axi
);

  localparam int DATA_W = 32;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    HUNG
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   araddr_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic [31:0]         wd_cnt;
  logic [31:0]         wd_next;
  logic                wd_hit;
  logic                aw_ok;
  logic                w_ok;
  logic                b_fire;
  logic                ar_fire;
  logic                r_fire;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = rready_q;

  // A channel counts as finished once its VALID has dropped or is handshaking now.
  assign aw_ok   = !awvalid_q || m_axi.awready;
  assign w_ok    = !wvalid_q  || m_axi.wready;
  assign b_fire  = bready_q  && m_axi.bvalid;
  assign ar_fire = arvalid_q && m_axi.arready;
  assign r_fire  = rready_q  && m_axi.rvalid;

  // The timeout takes effect on the same edge the count becomes TIMEOUT_CYCLES;
  // any completing handshake on that edge takes priority over it.
  assign wd_next = wd_cnt + 32'd1;
  assign wd_hit  = (TIMEOUT_CYCLES != 0) && (wd_next == TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idle      <= 1'b1;
      done      <= 1'b0;
      resp      <= 2'b00;
      rdata     <= '0;
      timed_out <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) wd_cnt <= wd_next;

      unique case (state)
        IDLE: begin
          if (cmd_write) begin
            awaddr_q  <= cmd_addr;
            wdata_q   <= cmd_wdata;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wd_cnt    <= '0;
            idle      <= 1'b0;
            state     <= WR_AW_W;
          end else if (cmd_read) begin
            araddr_q  <= cmd_addr;
            arvalid_q <= 1'b1;
            wd_cnt    <= '0;
            idle      <= 1'b0;
            state     <= RD_AR;
          end
        end

        WR_AW_W: begin
          if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state    <= WR_B;
          end else if (wd_hit) begin
            timed_out <= 1'b1;
            done      <= 1'b1;
            resp      <= RESP_SLVERR;
            state     <= HUNG;
          end
        end

        WR_B: begin
          if (b_fire) begin
            bready_q <= 1'b0;
            resp     <= m_axi.bresp;
            done     <= 1'b1;
            idle     <= 1'b1;
            state    <= IDLE;
          end else if (wd_hit) begin
            timed_out <= 1'b1;
            done      <= 1'b1;
            resp      <= RESP_SLVERR;
            state     <= HUNG;
          end
        end

        RD_AR: begin
          if (ar_fire) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_R;
          end else if (wd_hit) begin
            timed_out <= 1'b1;
            done      <= 1'b1;
            resp      <= RESP_SLVERR;
            state     <= HUNG;
          end
        end

        RD_R: begin
          if (r_fire) begin
            rready_q <= 1'b0;
            rdata    <= m_axi.rdata;
            resp     <= m_axi.rresp;
            done     <= 1'b1;
            idle     <= 1'b1;
            state    <= IDLE;
          end else if (wd_hit) begin
            timed_out <= 1'b1;
            done      <= 1'b1;
            resp      <= RESP_SLVERR;
            state     <= HUNG;
          end
        end

        // Outstanding VALID/READY stay as they were; only reset leaves this state.
        HUNG: state <= HUNG;

        default: begin
          idle  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: drives the slave side of the bus cycle by cycle.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_write, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        idle, done, timed_out;
  logic [1:0]  resp;
  logic [31:0] rdata;
  int          errors = 0;
  int          checks = 0;

  axil_cmd_master_if bus ();

  axil_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_write (cmd_write),
    .cmd_read  (cmd_read),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .idle      (idle),
    .done      (done),
    .resp      (resp),
    .rdata     (rdata),
    .timed_out (timed_out),
    .m_axi     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; cmd_write = 0; cmd_read = 0; cmd_addr = 0; cmd_wdata = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    tick(); tick();

    // Reset values
    chk("rst_idle", idle, 1);          chk("rst_done", done, 0);
    chk("rst_awvalid", bus.awvalid, 0); chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_arvalid", bus.arvalid, 0); chk("rst_bready", bus.bready, 0);
    chk("rst_rready", bus.rready, 0);   chk("rst_resp", resp, 0);
    chk("rst_rdata", rdata, 0);         chk("rst_timed_out", timed_out, 0);
    chk("rst_awaddr", bus.awaddr, 0);   chk("rst_wstrb", bus.wstrb, 4'hF);
    chk("rst_prot", {bus.awprot, bus.arprot}, 0);
    reset = 1'b0;
    tick();

    // Zero-wait write: addr 0x4, data 0x12345678
    cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'h12345678;
    bus.awready = 1; bus.wready = 1;
    tick();
    cmd_write = 0;
    chk("w0_awvalid", bus.awvalid, 1); chk("w0_wvalid", bus.wvalid, 1);
    chk("w0_awaddr", bus.awaddr, 32'h4); chk("w0_wdata", bus.wdata, 32'h12345678);
    chk("w0_wstrb", bus.wstrb, 4'hF);  chk("w0_idle", idle, 0);
    chk("w0_done_c1", done, 0);
    tick();
    chk("w0_awvalid_c2", bus.awvalid, 0); chk("w0_wvalid_c2", bus.wvalid, 0);
    chk("w0_bready_c2", bus.bready, 1);   chk("w0_done_c2", done, 0);
    bus.bvalid = 1; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 0;
    chk("w0_done_c3", done, 1); chk("w0_resp", resp, 0);
    chk("w0_bready_c3", bus.bready, 0); chk("w0_idle_c3", idle, 1);
    tick();
    chk("w0_done_c4", done, 0);

    // Skewed write: AWREADY in cycle 1, WREADY in cycle 5
    cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'hCAFEF00D;
    bus.awready = 1; bus.wready = 0;
    tick();
    cmd_write = 0;
    chk("ws_awvalid_c1", bus.awvalid, 1); chk("ws_wvalid_c1", bus.wvalid, 1);
    tick();
    bus.awready = 0;
    for (int i = 2; i <= 5; i++) begin
      chk("ws_awvalid_low", bus.awvalid, 0);
      chk("ws_wvalid_held", bus.wvalid, 1);
      chk("ws_bready_low", bus.bready, 0);
      if (i == 5) bus.wready = 1;
      tick();
    end
    bus.wready = 0;
    chk("ws_wvalid_c6", bus.wvalid, 0); chk("ws_bready_c6", bus.bready, 1);
    chk("ws_done_c6", done, 0);
    bus.bvalid = 1; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 0;
    chk("ws_done_c7", done, 1); chk("ws_resp", resp, 0); chk("ws_idle", idle, 1);
    tick();

    // Read of 0x0, 4 wait cycles before RVALID, RDATA = 314159
    cmd_read = 1; cmd_addr = 32'h0; bus.arready = 1;
    tick();
    cmd_read = 0;
    chk("r_arvalid_c1", bus.arvalid, 1); chk("r_araddr", bus.araddr, 0);
    chk("r_idle_c1", idle, 0);
    tick();
    bus.arready = 0;
    chk("r_arvalid_c2", bus.arvalid, 0);
    for (int i = 0; i < 4; i++) begin
      chk("r_rready_wait", bus.rready, 1);
      chk("r_done_wait", done, 0);
      tick();
    end
    bus.rvalid = 1; bus.rdata = 32'd314159; bus.rresp = 2'b00;
    tick();
    bus.rvalid = 0; bus.rdata = 0;
    chk("r_done", done, 1); chk("r_rdata", rdata, 32'd314159);
    chk("r_resp", resp, 0); chk("r_rready_off", bus.rready, 0);
    tick();
    chk("r_done_single", done, 0); chk("r_idle_after", idle, 1);

    // Write to 0x40 answered with DECERR; rdata must be untouched
    cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h0BADF00D;
    bus.awready = 1; bus.wready = 1;
    tick();
    cmd_write = 0;
    chk("de_awaddr", bus.awaddr, 32'h40);
    tick();
    bus.bvalid = 1; bus.bresp = 2'b11;
    tick();
    bus.bvalid = 0; bus.bresp = 0;
    chk("de_done", done, 1); chk("de_resp", resp, 3);
    chk("de_rdata_kept", rdata, 32'd314159);
    tick();

    // Read returning 0xAA with OKAY clears the error response
    cmd_read = 1; cmd_addr = 32'h40; bus.arready = 1;
    tick();
    cmd_read = 0;
    tick();
    bus.arready = 0;
    bus.rvalid = 1; bus.rdata = 32'hAA; bus.rresp = 2'b00;
    tick();
    bus.rvalid = 0;
    chk("aa_done", done, 1); chk("aa_rdata", rdata, 32'hAA); chk("aa_resp", resp, 0);
    tick();

    // Simultaneous write+read, then a read while busy: only the write happens
    cmd_write = 1; cmd_read = 1; cmd_addr = 32'h10; cmd_wdata = 32'h55;
    bus.awready = 1; bus.wready = 1;
    tick();
    cmd_write = 0; cmd_read = 1; cmd_addr = 32'h20;
    chk("sim_awvalid", bus.awvalid, 1); chk("sim_arvalid_c1", bus.arvalid, 0);
    chk("sim_awaddr", bus.awaddr, 32'h10);
    tick();
    cmd_read = 0;
    chk("sim_arvalid_c2", bus.arvalid, 0); chk("sim_bready", bus.bready, 1);
    bus.bvalid = 1; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 0;
    chk("sim_done", done, 1); chk("sim_arvalid_c3", bus.arvalid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sim_no_extra_done", done, 0);
      chk("sim_no_ar", bus.arvalid, 0);
      chk("sim_idle", idle, 1);
    end

    // Watchdog: ARREADY never comes, TIMEOUT_CYCLES = 16
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    cmd_read = 1; cmd_addr = 32'h80;
    tick();
    cmd_read = 0;
    for (int i = 0; i < 16; i++) begin
      chk("to_done_early", done, 0);
      chk("to_flag_early", timed_out, 0);
      tick();
    end
    chk("to_done", done, 1); chk("to_timed_out", timed_out, 1);
    chk("to_resp", resp, 2); chk("to_arvalid", bus.arvalid, 1);
    chk("to_idle", idle, 0);
    tick();
    chk("to_done_pulse", done, 0); chk("to_sticky", timed_out, 1);
    chk("to_arvalid_held", bus.arvalid, 1); chk("to_idle_held", idle, 0);

    // Asynchronous reset mid-hang returns everything to reset values
    reset = 1'b1;
    #1;
    chk("ar_idle", idle, 1);           chk("ar_timed_out", timed_out, 0);
    chk("ar_arvalid", bus.arvalid, 0); chk("ar_araddr", bus.araddr, 0);
    chk("ar_resp", resp, 0);           chk("ar_rdata", rdata, 0);
    chk("ar_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_idle_after", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
